// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS-style multiply/divide unit with HI/LO result registers.
// Runs MULTU/MULT/DIVU/DIV with one bit per cycle. Latency is the same for every
// operand value, including divide by zero.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start, op          begin an operation (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   srcA, srcB         multiplicand/dividend and multiplier/divisor, sampled with start
//   busy, done         operation in progress / one-cycle completion pulse
//   hi, lo             product halves, or remainder and quotient
//   divByZero          divide with srcB=0; held until the next done
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divByZero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;      // product / quotient sign
    logic               neg_r;      // remainder sign (dividend sign)
    logic               dz;
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi;     // product upper half or partial remainder
    logic [WIDTH-1:0]   acc_lo;     // multiplier bits or quotient bits

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dshift, ddiff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? RUN : IDLE;
            RUN:        if (count == '0) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        a_neg = op[0] & srcA[WIDTH-1];
        b_neg = op[0] & srcB[WIDTH-1];
        a_mag = a_neg ? -srcA : srcA;
        b_mag = b_neg ? -srcB : srcB;

        msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

        // The remainder is always below the divisor, so the shifted value is below
        // twice the divisor and the top bit of the difference is a true borrow.
        // With a zero divisor the shifted value never reaches bit WIDTH, so every
        // quotient bit is 1 and the remainder ends up as the dividend magnitude.
        dshift = {acc_hi, acc_lo[WIDTH-1]};
        ddiff  = dshift - {1'b0, opnd};

        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = dz ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi        <= '0;
            lo        <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= op[1] && (srcB == '0);
                        opnd   <= op[1] ? b_mag : a_mag;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        acc_hi <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                        if (is_div) begin
                            acc_hi <= ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], ~ddiff[WIDTH]};
                        end else begin
                            acc_hi <= msum[WIDTH:1];
                            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    divByZero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] srcA = '0;
    logic [WIDTH-1:0] srcB = '0;
    logic             busy, done, divByZero;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait for done. lat counts edges from the edge that
    // samples start to the edge after which done is seen.
    task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit in_done_cycle, output int lat, output int busy_cycles);
        if (!in_done_cycle) @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; srcA = ~a; srcB = ~b; op = ~o;
        lat = 0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        n_checks++; if (divByZero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", divByZero); end
        // rst and start together: rst wins
        @(negedge clk);
        op = 2'b00; srcA = 32'd3; srcB = 32'd3; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy2: got %b expected 0", busy); end
    endtask

    task automatic test_multu();
        int lat, bc;
        do_op(2'b00, 32'd15, 32'd32, 1'b0, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_in_done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h000001E0) begin n_fail++; $display("FAIL multu_lo: got %h expected 000001e0", lo); end
        n_checks++; if (divByZero !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b expected 0", divByZero); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
        n_checks++; if (lo !== 32'h000001E0) begin n_fail++; $display("FAIL multu_lo_hold: got %h expected 000001e0", lo); end

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_mult();
        int lat, bc;
        do_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d expected 34", lat); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
        do_op(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, lat, bc);
        n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL mult_pos_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h00000006) begin n_fail++; $display("FAIL mult_pos_lo: got %h expected 00000006", lo); end
    endtask

    task automatic test_div_back_to_back();
        int lat, bc;
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, lat, bc);
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        // start issued in the DONE cycle
        do_op(2'b10, 32'd100, 32'd7, 1'b1, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bc);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
        n_checks++; if (divByZero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b expected 0", divByZero); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        do_op(2'b10, 32'd15, 32'd0, 1'b0, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
        n_checks++; if (hi !== 32'h0000000F) begin n_fail++; $display("FAIL dbz_hi: got %h expected 0000000f", hi); end
        n_checks++; if (divByZero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", divByZero); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (divByZero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b expected 1", divByZero); end
        do_op(2'b10, 32'd9, 32'd3, 1'b0, lat, bc);
        n_checks++; if (divByZero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b expected 0", divByZero); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_9_3_lo: got %h expected 00000003", lo); end
        do_op(2'b11, 32'hFFFFFFFB, 32'd0, 1'b0, lat, bc);
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sdbz_lo: got %h expected ffffffff", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL sdbz_hi: got %h expected fffffffb", hi); end
        n_checks++; if (divByZero !== 1'b1) begin n_fail++; $display("FAIL sdbz_flag: got %b expected 1", divByZero); end
    endtask

    // A second start while busy is dropped; the first operation completes unchanged.
    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        op = 2'b00; srcA = 32'd6; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 4) begin op = 2'b10; srcA = 32'd100; srcB = 32'd10; start = 1'b1; end
            if (lat == 5) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL ignore_lo: got %h expected 0000002a", lo); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued: got %b expected 0", busy); end
    endtask

    // Reset in the middle of an operation; hi/lo hold while busy until then.
    task automatic test_reset_mid_op();
        int ndone;
        @(negedge clk);
        op = 2'b00; srcA = 32'h1234; srcB = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin op = 2'b00; srcA = 32'd9; srcB = 32'd9; start = 1'b1; end
            if (k == 6) start = 1'b0;
            if (k == 10) rst = 1'b1;
            if (k == 5) begin
                n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL busy_lo_hold: got %h expected ffffffff", lo); end
                n_checks++; if (hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL busy_hi_hold: got %h expected fffffffb", hi); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid: got %b expected 1", busy); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 00000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo: got %h expected 00000000", lo); end
        n_checks++; if (divByZero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dbz: got %b expected 0", divByZero); end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div_back_to_back();
        test_overflow();
        test_busy_ignore();
        test_div_by_zero();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
